axi4lite_master_ctrl: RTL and testbench

AXI4LITE_MASTER_CTRL -- requirements
Module: axi4lite_master_ctrl

---
 rtl/axi4lite_master_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_axi4lite_master_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_master_ctrl.sv
// AXI4-Lite master controller.
// Accepts one read and one write request from the local side, then runs them
// one at a time on the AXI4-Lite bus and reports data/response with a
// single-cycle done pulse. Every output is driven straight from a flop.
//
// Handshake rule: a channel transfer happens on a rising edge where both
// valid and ready are 1; a master valid, once raised, stays high with its
// payload unchanged until that edge, however long the slave waits.

package axi4lite_pkg;
  localparam int ADDRWIDTH = 32;
  localparam int DATAWIDTH = 32;
endpackage

module axi4lite_master_ctrl #(
  parameter int ADDRWIDTH = axi4lite_pkg::ADDRWIDTH,
  parameter int DATAWIDTH = axi4lite_pkg::DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_N,
  // local request side
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [ADDRWIDTH-1:0] Read_Address,
  input  logic [ADDRWIDTH-1:0] Write_Address,
  input  logic [DATAWIDTH-1:0] Write_Data,
  output logic                 rd_ready,
  output logic                 wr_ready,
  output logic                 rd_done,
  output logic [DATAWIDTH-1:0] Read_Data,
  output logic [1:0]           rd_resp,
  output logic                 wr_done,
  output logic [1:0]           wr_resp,
  // AXI4-Lite write channels
  output logic [ADDRWIDTH-1:0] awaddr,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [DATAWIDTH-1:0] wdata,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  // AXI4-Lite read channels
  output logic [ADDRWIDTH-1:0] araddr,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [DATAWIDTH-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

  // last_grant encoding: the type served most recently loses the next tie
  localparam logic GRANT_WRITE = 1'b0;
  localparam logic GRANT_READ  = 1'b1;

  state_t                 state, state_nxt;
  logic                   last_grant, last_grant_nxt;
  logic                   rd_ready_nxt, wr_ready_nxt;
  logic [ADDRWIDTH-1:0]   rd_addr_q, rd_addr_nxt;
  logic [ADDRWIDTH-1:0]   wr_addr_q, wr_addr_nxt;
  logic [DATAWIDTH-1:0]   wr_data_q, wr_data_nxt;
  logic [ADDRWIDTH-1:0]   awaddr_nxt, araddr_nxt;
  logic [DATAWIDTH-1:0]   wdata_nxt, read_data_nxt;
  logic                   awvalid_nxt, wvalid_nxt, bready_nxt;
  logic                   arvalid_nxt, rready_nxt;
  logic                   rd_done_nxt, wr_done_nxt;
  logic [1:0]             rd_resp_nxt, wr_resp_nxt;

  // State register plus registered copies of every output and request slot
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state      <= IDLE;
      last_grant <= GRANT_WRITE;
      rd_ready   <= 1'b1;
      wr_ready   <= 1'b1;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      awaddr     <= '0;
      wdata      <= '0;
      araddr     <= '0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      Read_Data  <= '0;
      rd_resp    <= '0;
      wr_resp    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      rd_ready   <= rd_ready_nxt;
      wr_ready   <= wr_ready_nxt;
      rd_addr_q  <= rd_addr_nxt;
      wr_addr_q  <= wr_addr_nxt;
      wr_data_q  <= wr_data_nxt;
      awaddr     <= awaddr_nxt;
      wdata      <= wdata_nxt;
      araddr     <= araddr_nxt;
      awvalid    <= awvalid_nxt;
      wvalid     <= wvalid_nxt;
      bready     <= bready_nxt;
      arvalid    <= arvalid_nxt;
      rready     <= rready_nxt;
      rd_done    <= rd_done_nxt;
      wr_done    <= wr_done_nxt;
      Read_Data  <= read_data_nxt;
      rd_resp    <= rd_resp_nxt;
      wr_resp    <= wr_resp_nxt;
    end
  end

  // Request capture, arbitration and bus sequencing for the next edge
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    rd_ready_nxt   = rd_ready;
    wr_ready_nxt   = wr_ready;
    rd_addr_nxt    = rd_addr_q;
    wr_addr_nxt    = wr_addr_q;
    wr_data_nxt    = wr_data_q;
    awaddr_nxt     = awaddr;
    wdata_nxt      = wdata;
    araddr_nxt     = araddr;
    awvalid_nxt    = awvalid;
    wvalid_nxt     = wvalid;
    bready_nxt     = bready;
    arvalid_nxt    = arvalid;
    rready_nxt     = rready;
    rd_done_nxt    = 1'b0;
    wr_done_nxt    = 1'b0;
    read_data_nxt  = Read_Data;
    rd_resp_nxt    = rd_resp;
    wr_resp_nxt    = wr_resp;

    // A slot is pending while its ready is low; strobes then have no effect
    if (rd_en && rd_ready) begin
      rd_ready_nxt = 1'b0;
      rd_addr_nxt  = Read_Address;
    end
    if (wr_en && wr_ready) begin
      wr_ready_nxt = 1'b0;
      wr_addr_nxt  = Write_Address;
      wr_data_nxt  = Write_Data;
    end

    case (state)
      IDLE: begin
        if (!rd_ready && (wr_ready || last_grant == GRANT_WRITE)) begin
          state_nxt      = RADDR;
          last_grant_nxt = GRANT_READ;
          araddr_nxt     = rd_addr_q;
          arvalid_nxt    = 1'b1;
        end else if (!wr_ready) begin
          state_nxt      = WADDR;
          last_grant_nxt = GRANT_WRITE;
          awaddr_nxt     = wr_addr_q;
          wdata_nxt      = wr_data_q;
          awvalid_nxt    = 1'b1;
          wvalid_nxt     = 1'b1;
        end
      end
      WADDR: begin
        // AW and W complete independently; move on once both are done
        if (awready) awvalid_nxt = 1'b0;
        if (wready)  wvalid_nxt  = 1'b0;
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          state_nxt  = WRESP;
          bready_nxt = 1'b1;
        end
      end
      WRESP: begin
        if (bvalid) begin
          state_nxt    = IDLE;
          bready_nxt   = 1'b0;
          wr_resp_nxt  = bresp;
          wr_done_nxt  = 1'b1;
          wr_ready_nxt = 1'b1;
        end
      end
      RADDR: begin
        if (arready) begin
          state_nxt   = RDATA;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end
      end
      RDATA: begin
        if (rvalid) begin
          state_nxt     = IDLE;
          rready_nxt    = 1'b0;
          read_data_nxt = rdata;
          rd_resp_nxt   = rresp;
          rd_done_nxt   = 1'b1;
          rd_ready_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// Directed bench for axi4lite_master_ctrl with a small AXI4-Lite slave model
// and a scoreboard of expected completions (order, data, response).
module tb_axi4lite_master_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst_N;
  logic          rd_en, wr_en;
  logic [AW-1:0] Read_Address, Write_Address;
  logic [DW-1:0] Write_Data;
  logic          rd_ready, wr_ready, rd_done, wr_done;
  logic [DW-1:0] Read_Data;
  logic [1:0]    rd_resp, wr_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;

  // slave model state
  logic          use_addr;
  logic [DW-1:0] rdata_fix;
  logic [AW-1:0] slv_araddr, slv_awaddr;
  logic [DW-1:0] slv_wdata;

  // scoreboard: {rresp, rdata} per read, bresp per write, completion order
  logic [DW+1:0] exp_rd_q[$];
  logic [1:0]    exp_wr_q[$];
  logic          exp_ord_q[$];

  int checks;
  int failures;

  axi4lite_master_ctrl #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clk(clk), .rst_N(rst_N),
    .rd_en(rd_en), .wr_en(wr_en),
    .Read_Address(Read_Address), .Write_Address(Write_Address), .Write_Data(Write_Data),
    .rd_ready(rd_ready), .wr_ready(wr_ready),
    .rd_done(rd_done), .Read_Data(Read_Data), .rd_resp(rd_resp),
    .wr_done(wr_done), .wr_resp(wr_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // slave model: remembers what was handshaken, read data may track address
  always @(posedge clk) begin
    if (arvalid && arready) slv_araddr <= araddr;
    if (awvalid && awready) slv_awaddr <= awaddr;
    if (wvalid && wready)   slv_wdata  <= wdata;
  end
  assign rdata = use_addr ? {16'hC0DE, slv_araddr[15:0]} : rdata_fix;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: set the strobe and record what must come back
  task automatic req_read(input logic [AW-1:0] a, input logic [DW+1:0] exp);
    rd_en        = 1'b1;
    Read_Address = a;
    exp_rd_q.push_back(exp);
    exp_ord_q.push_back(1'b0);
  endtask

  task automatic req_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] r);
    wr_en         = 1'b1;
    Write_Address = a;
    Write_Data    = d;
    exp_wr_q.push_back(r);
    exp_ord_q.push_back(1'b1);
  endtask

  // wait for the next done pulse and compare it with the scoreboard head
  task automatic complete(input string tag, input int exp_cyc);
    int            cyc;
    logic          exp_wr;
    logic [DW+1:0] er;
    logic [1:0]    ew;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!rd_done && !wr_done && cyc < 60);
    chk({tag, "_done_seen"}, 64'(rd_done | wr_done), 64'(1));
    if (!rd_done && !wr_done) return;
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, "_queue_nonempty"}, 64'(exp_ord_q.size() > 0), 64'(1));
    if (exp_ord_q.size() == 0) return;
    exp_wr = exp_ord_q.pop_front();
    chk({tag, "_order_is_write"}, 64'(wr_done), 64'(exp_wr));
    if (wr_done && exp_wr_q.size() > 0) begin
      ew = exp_wr_q.pop_front();
      chk({tag, "_wr_resp"}, 64'(wr_resp), 64'(ew));
    end else if (rd_done && exp_rd_q.size() > 0) begin
      er = exp_rd_q.pop_front();
      chk({tag, "_read_data"}, 64'(Read_Data), 64'(er[DW-1:0]));
      chk({tag, "_rd_resp"}, 64'(rd_resp), 64'(er[DW+1:DW]));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rd_en = 0; wr_en = 0; Read_Address = '0; Write_Address = '0; Write_Data = '0;
    awready = 0; wready = 0; arready = 0; rvalid = 0; bvalid = 0;
    bresp = 2'b00; rresp = 2'b00; rdata_fix = '0; use_addr = 0;
    rst_N = 1'b1;
    #2 rst_N = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_ready", 64'(rd_ready), 64'(1));
    chk("rst_wr_ready", 64'(wr_ready), 64'(1));
    chk("rst_arvalid", 64'(arvalid), 64'(0));
    chk("rst_awvalid", 64'(awvalid), 64'(0));
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_bready", 64'(bready), 64'(0));
    chk("rst_rready", 64'(rready), 64'(0));
    chk("rst_dones", 64'({rd_done, wr_done}), 64'(0));
    chk("rst_araddr", 64'(araddr), 64'(0));
    chk("rst_read_data", 64'(Read_Data), 64'(0));
    rst_N = 1'b1;
    step();

    // single read, slave always ready
    arready = 1; rvalid = 1; awready = 1; wready = 1; bvalid = 1;
    rdata_fix = 32'hDEADBEEF;
    req_read(32'h10, {2'b00, 32'hDEADBEEF});
    step();
    rd_en = 0;
    chk("t1_rd_ready_low", 64'(rd_ready), 64'(0));
    chk("t1_no_early_ar", 64'(arvalid), 64'(0));
    step();
    chk("t1_arvalid", 64'(arvalid), 64'(1));
    chk("t1_araddr", 64'(araddr), 64'(32'h10));
    step();
    chk("t1_arvalid_drop", 64'(arvalid), 64'(0));
    chk("t1_rready", 64'(rready), 64'(1));
    complete("t1", 1);
    chk("t1_rready_drop", 64'(rready), 64'(0));
    chk("t1_rd_ready_back", 64'(rd_ready), 64'(1));
    step();
    chk("t1_done_one_cycle", 64'(rd_done), 64'(0));

    // back-to-back reads with rd_en held; non-OKAY read response reported
    use_addr = 1; rresp = 2'b11;
    req_read(32'h30, {2'b11, 32'hC0DE0030});
    step();
    Read_Address = 32'h44;
    exp_rd_q.push_back({2'b11, 32'hC0DE0044});
    exp_ord_q.push_back(1'b0);
    complete("t2a", 3);
    chk("t2_done_edge_strobe_ignored", 64'(rd_ready), 64'(1));
    step();
    rd_en = 0;
    chk("t2_second_captured", 64'(rd_ready), 64'(0));
    complete("t2b", 3);

    // read with AR wait states: address and valid must hold
    arready = 0; rresp = 2'b00;
    req_read(32'h58, {2'b00, 32'hC0DE0058});
    step();
    rd_en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_arvalid_hold", 64'(arvalid), 64'(1));
      chk("t3_araddr_hold", 64'(araddr), 64'(32'h58));
    end
    arready = 1;
    complete("t3", 2);

    // write, W accepted three cycles after AW; early bvalid ignored
    use_addr = 0; awready = 1; wready = 0; bvalid = 1; bresp = 2'b01;
    req_write(32'h20, 32'hA5A5A5A5, 2'b01);
    step();
    wr_en = 0;
    chk("t4_wr_ready_low", 64'(wr_ready), 64'(0));
    step();
    chk("t4_awvalid", 64'(awvalid), 64'(1));
    chk("t4_wvalid", 64'(wvalid), 64'(1));
    chk("t4_awaddr", 64'(awaddr), 64'(32'h20));
    chk("t4_wdata", 64'(wdata), 64'(32'hA5A5A5A5));
    step();
    chk("t4_awvalid_drop_first", 64'(awvalid), 64'(0));
    chk("t4_wvalid_still", 64'(wvalid), 64'(1));
    chk("t4_no_bready_yet", 64'(bready), 64'(0));
    chk("t4_early_bvalid_ignored", 64'(wr_done), 64'(0));
    wr_en = 1; Write_Address = 32'h99; Write_Data = 32'h12345678;
    step();
    wr_en = 0;
    for (int i = 0; i < 2; i++) begin
      chk("t4_wvalid_hold", 64'(wvalid), 64'(1));
      chk("t4_wdata_original", 64'(wdata), 64'(32'hA5A5A5A5));
      chk("t4_bready_wait", 64'(bready), 64'(0));
      if (i == 0) step();
    end
    wready = 1; bvalid = 0;
    step();
    chk("t4_wvalid_drop", 64'(wvalid), 64'(0));
    chk("t4_bready", 64'(bready), 64'(1));
    step();
    chk("t4_bready_hold", 64'(bready), 64'(1));
    chk("t4_no_done_without_bvalid", 64'(wr_done), 64'(0));
    bvalid = 1;
    complete("t4", 1);
    chk("t4_bready_drop", 64'(bready), 64'(0));
    chk("t4_slave_awaddr", 64'(slv_awaddr), 64'(32'h20));
    chk("t4_slave_wdata", 64'(slv_wdata), 64'(32'hA5A5A5A5));
    step();
    chk("t4_done_one_cycle", 64'(wr_done), 64'(0));
    chk("t4_no_stale_request", 64'(wr_ready), 64'(1));
    chk("t4_idle_awvalid", 64'(awvalid), 64'(0));

    // write, W accepted before AW
    awready = 0; wready = 1; bresp = 2'b00;
    req_write(32'h28, 32'h0F0F0F0F, 2'b00);
    step();
    wr_en = 0;
    step();
    chk("t5_both_valid", 64'({awvalid, wvalid}), 64'(2'b11));
    step();
    chk("t5_w_first", 64'({awvalid, wvalid}), 64'(2'b10));
    chk("t5_no_bready", 64'(bready), 64'(0));
    awready = 1;
    step();
    chk("t5_aw_done", 64'(awvalid), 64'(0));
    chk("t5_bready", 64'(bready), 64'(1));
    complete("t5", 1);
    chk("t5_slave_awaddr", 64'(slv_awaddr), 64'(32'h28));
    chk("t5_slave_wdata", 64'(slv_wdata), 64'(32'h0F0F0F0F));

    // arbitration after reset: read first, then alternation
    use_addr = 1; arready = 1; rvalid = 1; awready = 1; wready = 1; bvalid = 1;
    rst_N = 0;
    step();
    rst_N = 1;
    step();
    req_read(32'h60, {2'b00, 32'hC0DE0060});
    req_write(32'h64, 32'h11112222, 2'b00);
    step();
    rd_en = 0; wr_en = 0;
    step();
    chk("t6_read_first_ar", 64'(arvalid), 64'(1));
    chk("t6_read_first_aw", 64'(awvalid), 64'(0));
    complete("t6a", 2);
    complete("t6b", 3);
    req_read(32'h68, {2'b00, 32'hC0DE0068});
    step();
    rd_en = 0;
    complete("t6c", 3);
    req_write(32'h6C, 32'h33334444, 2'b00);
    req_read(32'h70, {2'b00, 32'hC0DE0070});
    exp_ord_q.delete();
    exp_ord_q.push_back(1'b1);
    exp_ord_q.push_back(1'b0);
    step();
    rd_en = 0; wr_en = 0;
    step();
    chk("t6_write_first_aw", 64'(awvalid), 64'(1));
    chk("t6_write_first_ar", 64'(arvalid), 64'(0));
    complete("t6d", 2);
    chk("t6d_slave_wdata", 64'(slv_wdata), 64'(32'h33334444));
    complete("t6e", 3);

    // reset while the write address phase is stalled
    awready = 0; wready = 0;
    wr_en = 1; Write_Address = 32'h80; Write_Data = 32'hCAFEF00D;
    step();
    wr_en = 0;
    step();
    chk("t7_in_waddr", 64'(awvalid), 64'(1));
    rst_N = 0;
    #1;
    chk("t7_async_awvalid", 64'(awvalid), 64'(0));
    chk("t7_async_wvalid", 64'(wvalid), 64'(0));
    chk("t7_async_wr_ready", 64'(wr_ready), 64'(1));
    chk("t7_async_awaddr", 64'(awaddr), 64'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t7_no_wr_done", 64'(wr_done), 64'(0));
    end
    rst_N = 1;
    step();
    chk("t7_ready_after_release", 64'(wr_ready), 64'(1));
    awready = 1; wready = 1; bvalid = 1;
    req_write(32'h84, 32'h600DD00D, 2'b00);
    step();
    wr_en = 0;
    complete("t7", 3);
    chk("t7_slave_wdata", 64'(slv_wdata), 64'(32'h600DD00D));

    // SLVERR is reported and not retried
    bresp = 2'b10;
    req_write(32'h90, 32'h5555AAAA, 2'b10);
    step();
    wr_en = 0;
    complete("t8", 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t8_no_retry_aw", 64'(awvalid), 64'(0));
      chk("t8_no_second_done", 64'(wr_done), 64'(0));
      chk("t8_idle_ready", 64'(wr_ready), 64'(1));
    end

    chk("end_ord_queue_empty", 64'(exp_ord_q.size()), 64'(0));
    chk("end_rd_queue_empty", 64'(exp_rd_q.size()), 64'(0));
    chk("end_wr_queue_empty", 64'(exp_wr_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
